// File: rtl/gift_pkg.sv
// Shared GIFT-128 key-schedule definitions: widths, FSM states and the
// forward/inverse key-state and round-constant update functions.
package gift_pkg;

  localparam int KEY_W       = 128;
  localparam int RC_W        = 6;
  localparam int GIFT_ROUNDS = 40;

  typedef enum logic [1:0] {
    IDLE,
    WIND,
    EMIT
  } state_t;

  // One forward key-schedule step: rotate the two low words, shift the rest down.
  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] o;
    o[127:112] = {k[17:16], k[31:18]};
    o[111:96]  = {k[11:0], k[15:12]};
    o[95:0]    = k[127:32];
    return o;
  endfunction

  // Exact inverse of key_fwd.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] o;
    o[127:32] = k[95:0];
    o[31:16]  = {k[125:112], k[127:126]};
    o[15:0]   = {k[99:96], k[111:100]};
    return o;
  endfunction

  // Round-constant LFSR step forward.
  function automatic logic [RC_W-1:0] rc_fwd(input logic [RC_W-1:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

  // Round-constant LFSR step backward.
  function automatic logic [RC_W-1:0] rc_inv(input logic [RC_W-1:0] n);
    return {n[0] ^ n[5] ^ 1'b1, n[5:1]};
  endfunction

endpackage

// File: rtl/gift_keysch_inv_fun.sv
// Combinational inverse key-schedule update (pure wiring, no logic gates).
module gift_keysch_inv_fun
  import gift_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] key_prev
);

  // Undo one forward key-schedule step.
  always_comb begin
    key_prev = key_inv(key);
  end

endmodule

// File: rtl/gift_dec_key_seq.sv
// GIFT-128 decryption round-key sequencer: winds the schedule forward to the
// last round, then presents round keys and constants from ROUNDS down to 1.
module gift_dec_key_seq
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT_ROUNDS,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_key,
  output logic [5:0]       rk_rc,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_prev;
  logic [RC_W-1:0]  rc_reg;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             done_r;
  logic             accept;
  logic             last;
  logic             wind_last;

  assign accept    = (state == EMIT) && rk_ready;
  assign last      = accept && (idx == IDX_W'(1));
  assign wind_last = (state == WIND) && (cnt == IDX_W'(ROUNDS - 2));

  gift_keysch_inv_fun u_inv (
    .key      (key_reg),
    .key_prev (key_prev)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = WIND;
      WIND:    if (wind_last) state_nxt = EMIT;
      EMIT:    if (last)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode; key/constant/index come straight from their registers.
  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (state == EMIT);
    rk_key   = key_reg;
    rk_rc    = rc_reg;
    rk_idx   = idx;
    done     = done_r;
  end

  // Key, constant and counter datapath; the final accepted round leaves K_0 in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg <= '0;
      rc_reg  <= '0;
      cnt     <= '0;
      idx     <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= last;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg <= key_in;
            rc_reg  <= RC_W'(1);
            cnt     <= '0;
            idx     <= IDX_W'(ROUNDS);
          end
        end
        WIND: begin
          key_reg <= key_fwd(key_reg);
          rc_reg  <= rc_fwd(rc_reg);
          cnt     <= cnt + 1'b1;
        end
        EMIT: begin
          if (accept && !last) begin
            key_reg <= key_prev;
            rc_reg  <= rc_inv(rc_reg);
            idx     <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_dec_key_seq.sv
// Self-checking bench for gift_dec_key_seq: table-driven round-key sequences
// with stalls, ignored starts, mid-run resets and back-to-back runs.
module tb_gift_dec_key_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_key;
  logic [5:0]   rk_rc;
  logic [5:0]   rk_idx;
  logic         done;

  int nvec = 0;
  int nerr = 0;

  // GIFT round constants c_1..c_40.
  localparam logic [5:0] RC_TAB [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  typedef struct {
    bit           stall;
    logic [5:0]   idx;
    logic [5:0]   rc;
    logic [127:0] key;
  } vec_t;

  vec_t         vt [40];
  logic [127:0] kst [40];

  gift_dec_key_seq #(.ROUNDS(40), .IDX_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_key   (rk_key),
    .rk_rc    (rk_rc),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] model_fwd(input logic [127:0] k);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = k[31:16];
    lo = k[15:0];
    hi = (hi >> 2) | (hi << 14);
    lo = (lo << 4) | (lo >> 12);
    return {hi, lo, k[127:32]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},     busy,     0);
    chk({tag, " rk_valid"}, rk_valid, 0);
    chk({tag, " done"},     done,     0);
    chk({tag, " rk_key"},   rk_key,   0);
    chk({tag, " rk_rc"},    rk_rc,    0);
    chk({tag, " rk_idx"},   rk_idx,   0);
  endtask

  // Called at a negedge; drives start there and walks the whole sequence.
  task automatic run_seq(input logic [127:0] k0, input int stall_a, input int stall_b,
                         input bit pulse, input bit abort_wind, input bit abort_emit);
    int lat;
    kst[0] = k0;
    for (int j = 1; j < 40; j++) kst[j] = model_fwd(kst[j-1]);
    for (int i = 0; i < 40; i++) begin
      vt[i].idx   = 6'(40 - i);
      vt[i].rc    = RC_TAB[39 - i];
      vt[i].key   = kst[39 - i];
      vt[i].stall = (40 - i == stall_a) || (40 - i == stall_b);
    end

    key_in = k0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    lat    = 1;

    if (abort_wind) begin
      while (lat < 11) begin @(posedge clk); #1; lat++; end
      chk("wind busy before reset", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("reset in WIND");
      rst = 1'b0;
      return;
    end

    while (rk_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (pulse && lat == 5) start = 1'b1;
      if (pulse && lat == 6) start = 1'b0;
    end
    chk("latency start->rk_valid", lat, 40);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (abort_emit && vt[i].idx == 6'd20) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset in EMIT");
        rst = 1'b0;
        return;
      end
      chk("rk_valid", rk_valid, 1);
      chk("busy",     busy,     1);
      chk("rk_idx",   rk_idx,   vt[i].idx);
      chk("rk_rc",    rk_rc,    vt[i].rc);
      chk("rk_key",   rk_key,   vt[i].key);
      if (pulse && i == 10) start = 1'b1;
      if (vt[i].stall) begin
        rk_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall rk_valid", rk_valid, 1);
          chk("stall rk_idx",   rk_idx,   vt[i].idx);
          chk("stall rk_rc",    rk_rc,    vt[i].rc);
          chk("stall rk_key",   rk_key,   vt[i].key);
        end
        rk_ready = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    chk("done pulse",          done,     1);
    chk("rk_valid after last", rk_valid, 0);
    chk("busy after last",     busy,     0);
  endtask

  initial begin
    logic [127:0] kr;
    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b1;
    key_in   = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle after reset");

    // 1: all-zero key, full throughput
    run_seq('0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done falls", done, 0);
    chk("idle rk_idx holds", rk_idx, 1);

    // 2: single-bit key
    @(negedge clk);
    run_seq(128'h1, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("final key is K_0", rk_key, 128'h1);

    // 3: random key with stalls at rounds 40 and 17
    @(negedge clk);
    kr = {$urandom, $urandom, $urandom, $urandom};
    run_seq(kr, 40, 17, 1'b0, 1'b0, 1'b0);
    chk("final key == key_in", rk_key, kr);

    // 4: start pulses while busy are ignored
    @(negedge clk);
    run_seq(128'h1, 0, 0, 1'b1, 1'b0, 1'b0);

    // 5: reset mid-WIND and mid-EMIT, each followed by a clean run
    @(negedge clk);
    run_seq(128'h1, 0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_seq(128'h1, 0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run_seq(128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, 0, 0, 1'b0, 1'b0, 1'b0);

    // 6: back-to-back, second start lands in the done cycle
    @(negedge clk);
    run_seq(128'h0F0F_0000_1234_5678_0000_0000_8000_0001, 0, 0, 1'b0, 1'b0, 1'b0);
    run_seq(128'h1, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
